// File: rtl/traffic_light_pkg.sv
// Shared lamp bundle, decoded phase type and monitor defaults.
package traffic_light_pkg;
    localparam int CNT_LED = 3;

    typedef struct packed {
        logic red;
        logic yellow;
        logic green;
    } tll;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        YELLOW = 2'd1,
        GREEN  = 2'd2,
        RED    = 2'd3
    } tl_phase_e;

    localparam int DARK_MAX_DEF      = 2;
    localparam int MAX_PHASE_CYC_DEF = 40;
endpackage

// File: rtl/tl_lamp_decode.sv
// Per-sample lamp decode: candidate phase with blink-dark tolerance, multi-lamp pulse.
// Candidate is combinational from the sample and the registered dark counter.
module tl_lamp_decode
    import traffic_light_pkg::*;
#(
    parameter int DARK_MAX = DARK_MAX_DEF
) (
    input  logic      clk,
    input  logic      rstn,
    input  logic      en_i,
    input  tll        tl_i,
    input  tl_phase_e phase_i,
    output tl_phase_e cand_o,
    output logic      multi_o
);
    localparam int DW = $clog2(DARK_MAX + 2);
    localparam logic [DW-1:0] DARK_OFF = DW'(DARK_MAX + 1);

    logic [DW-1:0]      dark_q, dark_d;
    logic [CNT_LED-1:0] lamps;
    logic [1:0]         n_lit;

    assign lamps = tl_i;

    always_comb begin
        n_lit = 2'd0;
        for (int i = 0; i < CNT_LED; i++) begin
            n_lit = n_lit + 2'(lamps[i]);
        end
    end

    always_comb begin
        dark_d  = dark_q;
        cand_o  = phase_i;
        multi_o = 1'b0;
        if (!en_i) begin
            dark_d = '0;
            cand_o = OFF;
        end else if (n_lit == 2'd1) begin
            dark_d = '0;
            if (tl_i.red)         cand_o = RED;
            else if (tl_i.yellow) cand_o = YELLOW;
            else                  cand_o = GREEN;
        end else if (n_lit == 2'd0) begin
            // Counter saturates at the OFF threshold so a long dark stays OFF.
            if (dark_q != DARK_OFF) dark_d = dark_q + 1'b1;
            if (dark_d == DARK_OFF) cand_o = OFF;
        end else begin
            dark_d  = '0;
            multi_o = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) dark_q <= '0;
        else       dark_q <= dark_d;
    end
endmodule

// File: rtl/traffic_light_monitor.sv
// Lamp-side checker: phase sequencing, exclusivity and duration, cycle counting.
// All outputs registered; phase_o follows a lit lamp one cycle later.
module traffic_light_monitor
    import traffic_light_pkg::*;
#(
    parameter int DARK_MAX      = DARK_MAX_DEF,
    parameter int MAX_PHASE_CYC = MAX_PHASE_CYC_DEF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        en_i,
    input  tll          tl_i,
    input  logic        err_clr_i,
    output tl_phase_e   phase_o,
    output logic [7:0]  phase_len_o,
    output logic [15:0] cycle_cnt_o,
    output logic        err_multi_o,
    output logic        err_seq_o,
    output logic        err_timeout_o
);
    tl_phase_e   phase_q, phase_d, prev_dir_q, prev_dir_d, cand;
    logic [7:0]  len_q, len_d, plen_q, plen_d;
    logic [15:0] cyc_q, cyc_d;
    logic        multi, new_seq, new_to;
    logic        e_multi_q, e_seq_q, e_to_q;

    tl_lamp_decode #(.DARK_MAX(DARK_MAX)) u_decode (
        .clk     (clk),
        .rstn    (rstn),
        .en_i    (en_i),
        .tl_i    (tl_i),
        .phase_i (phase_q),
        .cand_o  (cand),
        .multi_o (multi)
    );

    always_comb begin
        phase_d    = phase_q;
        prev_dir_d = prev_dir_q;
        len_d      = len_q;
        plen_d     = plen_q;
        cyc_d      = cyc_q;
        new_seq    = 1'b0;
        new_to     = 1'b0;
        if (!en_i) begin
            phase_d    = OFF;
            len_d      = '0;
            prev_dir_d = RED;
        end else if (cand != phase_q) begin
            phase_d = cand;
            if (phase_q != OFF) plen_d = len_q;
            len_d = (cand == OFF) ? 8'd0 : 8'd1;
            if (cand != OFF) begin
                case (phase_q)
                    OFF:    new_seq = (cand != RED);
                    RED, GREEN: begin
                        if (cand == YELLOW) prev_dir_d = phase_q;
                        else                new_seq    = 1'b1;
                    end
                    default: begin
                        // Leaving YELLOW: direction decides which way is legal.
                        if (cand == GREEN) new_seq = (prev_dir_q != RED);
                        else if (prev_dir_q == GREEN) cyc_d = cyc_q + 16'd1;
                        else new_seq = 1'b1;
                    end
                endcase
            end
        end else if (phase_q != OFF) begin
            if (len_q != 8'hFF) len_d = len_q + 8'd1;
            new_to = (len_d == 8'(MAX_PHASE_CYC + 1));
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            phase_q    <= OFF;
            prev_dir_q <= RED;
            len_q      <= '0;
            plen_q     <= '0;
            cyc_q      <= '0;
            e_multi_q  <= 1'b0;
            e_seq_q    <= 1'b0;
            e_to_q     <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            prev_dir_q <= prev_dir_d;
            len_q      <= len_d;
            plen_q     <= plen_d;
            cyc_q      <= cyc_d;
            e_multi_q  <= (e_multi_q & ~err_clr_i) | (multi & en_i);
            e_seq_q    <= (e_seq_q & ~err_clr_i) | new_seq;
            e_to_q     <= (e_to_q & ~err_clr_i) | new_to;
        end
    end

    assign phase_o       = phase_q;
    assign phase_len_o   = plen_q;
    assign cycle_cnt_o   = cyc_q;
    assign err_multi_o   = e_multi_q;
    assign err_seq_o     = e_seq_q;
    assign err_timeout_o = e_to_q;
endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor with a scoreboard of expected outputs.
module tb_traffic_light_monitor;
    import traffic_light_pkg::*;

    logic        clk = 1'b0;
    logic        rstn, en, clr;
    tll          tl;
    tl_phase_e   phase;
    logic [7:0]  plen;
    logic [15:0] cyc;
    logic        e_multi, e_seq, e_to;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        tl_phase_e ph;
        int        plen;
        int        cyc;
        int        err;
    } exp_t;
    exp_t sb[$];

    localparam tll L_0  = 3'b000;
    localparam tll L_R  = 3'b100;
    localparam tll L_Y  = 3'b010;
    localparam tll L_G  = 3'b001;
    localparam tll L_RY = 3'b110;
    localparam tll L_RG = 3'b101;

    always #5 clk = ~clk;

    traffic_light_monitor dut (
        .clk           (clk),
        .rstn          (rstn),
        .en_i          (en),
        .tl_i          (tl),
        .err_clr_i     (clr),
        .phase_o       (phase),
        .phase_len_o   (plen),
        .cycle_cnt_o   (cyc),
        .err_multi_o   (e_multi),
        .err_seq_o     (e_seq),
        .err_timeout_o (e_to)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Drive one sample, then compare against the entry queued for it.
    // plen/cyc of -1 are not compared; err is {multi,seq,timeout}.
    task automatic step(input string tag, input tll l, input tl_phase_e ph,
                        input int pl, input int cy, input int er);
        exp_t e;
        tl = l;
        e = '{ph, pl, cy, er};
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".phase"}, 32'(phase), 32'(e.ph));
        if (e.plen >= 0) chk({tag, ".plen"}, 32'(plen), 32'(e.plen));
        if (e.cyc >= 0)  chk({tag, ".cyc"}, 32'(cyc), 32'(e.cyc));
        chk({tag, ".err"}, 32'({e_multi, e_seq, e_to}), 32'(e.err));
    endtask

    initial begin
        rstn = 1'b0;
        en   = 1'b0;
        clr  = 1'b0;
        tl   = L_0;
        repeat (2) @(posedge clk);
        #1;
        step("reset", L_0, OFF, 0, 0, 0);

        rstn = 1'b1;
        en   = 1'b1;
        for (int i = 0; i < 10; i++) step("red", L_R, RED, 0, 0, 0);
        for (int i = 0; i < 10; i++) step("yel1", L_Y, YELLOW, 10, 0, 0);
        for (int i = 0; i < 10; i++) step("grn", L_G, GREEN, 10, 0, 0);
        for (int i = 0; i < 10; i++) step("yel2", L_Y, YELLOW, 10, 0, 0);
        step("red_cycle", L_R, RED, 10, 1, 0);

        step("blink0", L_R, RED, 10, 1, 0);
        step("blink1", L_0, RED, 10, 1, 0);
        step("blink2", L_R, RED, 10, 1, 0);
        step("blink3", L_0, RED, 10, 1, 0);
        step("blink4", L_0, RED, 10, 1, 0);
        step("blink5", L_R, RED, 10, 1, 0);
        step("dark1", L_0, RED, 10, 1, 0);
        step("dark2", L_0, RED, 10, 1, 0);
        step("dark3", L_0, OFF, 9, 1, 0);

        step("off_red", L_R, RED, 9, 1, 0);
        step("red2", L_R, RED, 9, 1, 0);
        step("skip_yel", L_G, GREEN, 2, 1, 3'b010);
        clr = 1'b1;
        step("clr", L_G, GREEN, 2, 1, 0);
        clr = 1'b0;

        step("multi", L_RY, GREEN, 2, 1, 3'b100);
        for (int i = 4; i <= 41; i++)
            step("grn_long", L_G, GREEN, 2, 1, (i == 41) ? 3'b101 : 3'b100);

        clr = 1'b1;
        step("clr_vs_multi", L_RG, GREEN, 2, 1, 3'b100);
        clr = 1'b0;

        en = 1'b0;
        step("disable", L_G, OFF, 2, 1, 3'b100);
        en = 1'b1;
        step("off_grn", L_G, GREEN, 2, 1, 3'b110);

        rstn = 1'b0;
        step("mid_reset", L_G, OFF, 0, 0, 0);
        rstn = 1'b1;
        step("after_reset", L_R, RED, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Passive checker on the lamp side of the traffic light controller. It samples the `tll` lamp bundle each cycle and reconstructs the current phase, tolerating blink-dark cycles. It checks phase sequencing, lamp exclusivity and phase duration, and reports the last phase length and the count of completed cycles to the bench and to status logic.

## Interface
- `DARK_MAX`, default 2: consecutive all-dark cycles tolerated inside a phase before the monitor decodes OFF.
- `MAX_PHASE_CYC`, default 40: maximum legal length of a non-OFF phase, in cycles.
- `clk` in 1: clock.
- `rstn` in 1: reset, synchronous, active-low.
- `en_i` in 1: monitor enable.
- `tl_i` in `tll` (3): lamp bundle `red`/`yellow`/`green` from the controller.
- `err_clr_i` in 1: clears all sticky error flags.
- `phase_o` out `tl_phase_e` (2): decoded phase; OFF=0, YELLOW=1, GREEN=2, RED=3.
- `phase_len_o` out 8: length of the last completed non-OFF phase in cycles; saturates at 255.
- `cycle_cnt_o` out 16: completed RED→YELLOW→GREEN→YELLOW→RED cycles; wraps at 16 bits.
- `err_multi_o` out 1: sticky; more than one lamp lit in one sample.
- `err_seq_o` out 1: sticky; illegal phase transition.
- `err_timeout_o` out 1: sticky; phase exceeded `MAX_PHASE_CYC`.

## Operation
- Reset (`rstn`=0) sets: `phase_o`=OFF, `phase_len_o`=0, `cycle_cnt_o`=0, all error flags 0, internal length counter 0, dark counter 0, `prev_dir`=RED.
- Lamp decode of each sample:
  - Exactly one lamp lit: that lamp's phase is the candidate. The dark counter clears.
  - No lamp lit: the current phase holds and the dark counter increments. When the dark counter reaches `DARK_MAX`+1, the candidate becomes OFF.
  - More than one lamp lit: set `err_multi_o`. The phase holds and the dark counter clears.
- Transition occurs when the candidate differs from `phase_o`. On a transition:
  - `phase_o` takes the candidate.
  - `phase_len_o` takes the internal length if the old phase was not OFF.
  - The internal length counter restarts at 1.
- Legal transitions:
  - OFF→RED.
  - RED→YELLOW and GREEN→YELLOW. Each records `prev_dir` as the phase left.
  - YELLOW→GREEN only when `prev_dir`=RED.
  - YELLOW→RED only when `prev_dir`=GREEN. This transition also increments `cycle_cnt_o`.
  - Any phase→OFF.
- Any other transition sets `err_seq_o`. `phase_o` still follows the candidate.
- Length counting:
  - The internal length counter increments every cycle while the phase is not OFF, saturating at 255.
  - When it passes `MAX_PHASE_CYC`, `err_timeout_o` sets once per phase.
- `en_i`=0:
  - `phase_o` is forced to OFF; the length and dark counters clear; `prev_dir` goes to RED.
  - `cycle_cnt_o`, `phase_len_o` and the error flags hold.
  - No errors are raised while disabled.
- `err_clr_i`:
  - Clears all three error flags on the next edge.
  - If a new error is detected in the same cycle, the error wins and its flag stays 1.
- Reset mid-phase: all state returns to reset values on the next edge, with no error raised.

## Timing
- All outputs are registered.
- Latency from `tl_i` to `phase_o` is 1 cycle for a lit lamp.
- Entry to OFF is reported `DARK_MAX`+1 cycles after the first all-dark sample, plus 1 cycle of register latency.
- `err_*`, `phase_len_o` and `cycle_cnt_o` update on the same edge as the triggering `phase_o` change or sample.
- `err_timeout_o` asserts on the edge where the internal length becomes `MAX_PHASE_CYC`+1.

## Structure
- `traffic_light_pkg` holds:
  - the existing `tll` struct and `CNT_LED`;
  - the new `tl_phase_e` enum (OFF, YELLOW, GREEN, RED; 2-bit);
  - the `DARK_MAX` and `MAX_PHASE_CYC` defaults as localparams.
- Sub-module `tl_lamp_decode`:
  - Registered dark counter plus one-hot check.
  - Outputs the candidate phase and a multi-lamp pulse.
- The top level holds the transition legality logic, the counters and the sticky flags.

## Test plan
- Reset, then `en_i`=1 and red held 5 cycles → `phase_o`=RED at cycle 2; all errors 0.
- Full cycle: RED 10, YELLOW 10, GREEN 10, YELLOW 10, RED 1 → `cycle_cnt_o`=1, `phase_len_o`=10 after each completed phase, no errors.
- Blink in RED (1,0,1,0,0,1) → `phase_o` stays RED. Then 3 dark cycles → `phase_o`=OFF one cycle later.
- RED then GREEN with no YELLOW → `err_seq_o`=1, `phase_o`=GREEN. Assert `err_clr_i` one cycle → flag 0.
- red+yellow lit together → `err_multi_o`=1 and the phase holds. Green held 41 cycles → `err_timeout_o`=1 at the 41st length count.
- `err_clr_i` in the same cycle as a new multi-lamp sample → `err_multi_o` stays 1. `rstn`=0 mid-GREEN → all outputs return to reset values.
